// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO block: register addresses and reset values.
package apb_gpio_pkg;

    localparam int unsigned ADDR_DIR  = 0;
    localparam int unsigned ADDR_MODE = 1;
    localparam int unsigned ADDR_OUT  = 2;
    localparam int unsigned ADDR_PIN  = 3;

    localparam int unsigned RST_DIR   = 0;
    localparam int unsigned RST_MODE  = 0;
    localparam int unsigned RST_OUT   = 0;
    localparam int unsigned RST_SYNC  = 0;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer bringing asynchronous pad inputs into the pclk domain.
module gpio_sync
    import apb_gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge pclk) begin
        if (preset) begin
            meta <= WIDTH'(RST_SYNC);
            q    <= WIDTH'(RST_SYNC);
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/apb_gpio.sv
// APB slave for an 8-bit GPIO port: DIR/MODE/OUT registers, synchronized PIN
// read-back and push-pull / open-drain pad enable generation.
module apb_gpio
    import apb_gpio_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out,
    output logic [DATA_W-1:0] gpio_oe
);

    logic [DATA_W-1:0] dir_reg;
    logic [DATA_W-1:0] mode_reg;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] sync_in;
    logic [DATA_W-1:0] pin_val;
    logic              write_en;
    logic              read_en;

    assign pready   = 1'b1;
    assign write_en = psel & penable & pwrite;
    assign read_en  = psel & penable & ~pwrite;

    gpio_sync #(.WIDTH(DATA_W)) u_sync (
        .pclk   (pclk),
        .preset (preset),
        .d      (gpio_in),
        .q      (sync_in)
    );

    // Level-qualified: a held access phase simply rewrites the same value.
    always_ff @(posedge pclk) begin
        if (preset) begin
            dir_reg  <= DATA_W'(RST_DIR);
            mode_reg <= DATA_W'(RST_MODE);
            out_reg  <= DATA_W'(RST_OUT);
        end else if (write_en) begin
            case (paddr)
                ADDR_W'(ADDR_DIR):  dir_reg  <= pwdata;
                ADDR_W'(ADDR_MODE): mode_reg <= pwdata;
                ADDR_W'(ADDR_OUT):  out_reg  <= pwdata;
                default: ;
            endcase
        end
    end

    // Output pins read back their driven value, input pins the synchronized pad.
    assign pin_val = (dir_reg & out_reg) | (~dir_reg & sync_in);

    always_comb begin
        prdata = '0;
        if (read_en) begin
            case (paddr)
                ADDR_W'(ADDR_DIR):  prdata = dir_reg;
                ADDR_W'(ADDR_MODE): prdata = mode_reg;
                ADDR_W'(ADDR_OUT):  prdata = out_reg;
                ADDR_W'(ADDR_PIN):  prdata = pin_val;
                default:            prdata = '0;
            endcase
        end
    end

    // Open-drain pins only ever drive low; a 1 releases the pad.
    assign gpio_oe  = dir_reg & (mode_reg | ~out_reg);
    assign gpio_out = dir_reg & mode_reg & out_reg;

endmodule

// File: tb/tb_apb_gpio.sv
// Self-checking bench for apb_gpio: directed scenarios plus randomized traffic
// against a per-pin behavioural model.
module tb_apb_gpio;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic [3:0] paddr = '0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = '0;
    logic [7:0] prdata;
    logic       pready;
    logic [7:0] gpio_in = '0;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;

    int vectors = 0;
    int miscompares = 0;

    // model state: register contents and the settled pad input level
    logic [7:0] m_dir, m_mode, m_out, m_in;

    apb_gpio dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe)
    );

    always #5 pclk = ~pclk;

    function automatic void model_reset();
        m_dir = 8'h00; m_mode = 8'h00; m_out = 8'h00;
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        if (a == 0) m_dir = d;
        else if (a == 1) m_mode = d;
        else if (a == 2) m_out = d;
    endfunction

    function automatic logic [7:0] model_pin(input logic [7:0] pins);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (m_dir[i]) r[i] = m_out[i];
            else          r[i] = pins[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        case (a)
            0: return m_dir;
            1: return m_mode;
            2: return m_out;
            3: return model_pin(m_in);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_oe();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (!m_dir[i])     r[i] = 1'b0;
            else if (m_mode[i]) r[i] = 1'b1;
            else               r[i] = !m_out[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = m_dir[i] && m_mode[i] && m_out[i];
        return r;
    endfunction

    task automatic apb_write(input int a, input logic [7:0] d);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'(a); pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        vectors++;
        if (prdata !== 8'h00) begin
            miscompares++;
            $display("FAIL prdata_during_write addr=%0d got=%h exp=00", a, prdata);
        end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_write(a, d);
    endtask

    task automatic apb_read(input int a, output logic [7:0] d);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'(a);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        d = prdata;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        preset = 1'b1;
        gpio_in = 8'h34;
        m_in = 8'h34;
        model_reset();
        repeat (10) @(negedge pclk);
        vectors++;
        if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || pready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pads out=%h oe=%h rdy=%b exp 00/00/1", gpio_out, gpio_oe, pready);
        end
        preset = 1'b0;
        for (int a = 0; a < 3; a++) begin
            apb_read(a, d);
            vectors++;
            if (d !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d got=%h exp=00", a, d);
            end
        end
    endtask

    task automatic test_push_pull_open_drain();
        logic [7:0] d;
        apb_write(2, 8'hAA);
        apb_write(0, 8'hFF);
        apb_write(1, 8'hFF);
        vectors++;
        if (gpio_out !== 8'hAA || gpio_oe !== 8'hFF) begin
            miscompares++;
            $display("FAIL push_pull_pads out=%h oe=%h exp AA/FF", gpio_out, gpio_oe);
        end
        for (int a = 0; a < 3; a++) begin
            apb_read(a, d);
            vectors++;
            if (d !== model_read(a)) begin
                miscompares++;
                $display("FAIL pp_read addr=%0d got=%h exp=%h", a, d, model_read(a));
            end
        end
        apb_write(1, 8'h00);
        vectors++;
        if (gpio_out !== 8'h00 || gpio_oe !== 8'h55) begin
            miscompares++;
            $display("FAIL open_drain_pads out=%h oe=%h exp 00/55", gpio_out, gpio_oe);
        end
    endtask

    task automatic test_pin_readback();
        logic [7:0] d;
        logic [7:0] old_pin, new_pin;
        apb_read(3, d);
        vectors++;
        if (d !== 8'hAA) begin
            miscompares++;
            $display("FAIL pin_all_out got=%h exp=AA", d);
        end
        apb_write(0, 8'h00);
        apb_read(3, d);
        vectors++;
        if (d !== 8'h34 || gpio_oe !== 8'h00) begin
            miscompares++;
            $display("FAIL pin_all_in got=%h oe=%h exp 34/00", d, gpio_oe);
        end
        apb_write(0, 8'h0F);
        apb_read(3, d);
        vectors++;
        if (d !== 8'h3A) begin
            miscompares++;
            $display("FAIL pin_mixed got=%h exp=3A", d);
        end
        // hold a PIN read access phase while the pads change to expose latency
        old_pin = model_pin(m_in);
        new_pin = model_pin(8'hC3);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'd3;
        gpio_in = 8'hC3;
        @(negedge pclk);
        vectors++;
        if (prdata !== old_pin) begin
            miscompares++;
            $display("FAIL sync_one_edge got=%h exp=%h", prdata, old_pin);
        end
        @(negedge pclk);
        vectors++;
        if (prdata !== new_pin) begin
            miscompares++;
            $display("FAIL sync_two_edges got=%h exp=%h", prdata, new_pin);
        end
        psel = 1'b0; penable = 1'b0;
        m_in = 8'hC3;
    endtask

    task automatic test_access_hold();
        logic [7:0] d;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h5C;
        @(negedge pclk);
        penable = 1'b1;
        repeat (3) @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_write(2, 8'h5C);
        for (int a = 0; a < 3; a++) begin
            apb_read(a, d);
            vectors++;
            if (d !== model_read(a)) begin
                miscompares++;
                $display("FAIL hold_read addr=%0d got=%h exp=%h", a, d, model_read(a));
            end
        end
        vectors++;
        if (gpio_out !== model_out() || gpio_oe !== model_oe()) begin
            miscompares++;
            $display("FAIL hold_pads out=%h oe=%h exp %h/%h", gpio_out, gpio_oe, model_out(), model_oe());
        end
        // setup phase only, never followed by an access phase
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'hFF;
        repeat (2) @(negedge pclk);
        psel = 1'b0; pwrite = 1'b0;
        apb_read(2, d);
        vectors++;
        if (d !== 8'h5C) begin
            miscompares++;
            $display("FAIL setup_only got=%h exp=5C", d);
        end
    endtask

    task automatic test_reserved();
        logic [7:0] d;
        apb_write(3, 8'hFF);
        apb_write(9, 8'hFF);
        for (int a = 0; a < 3; a++) begin
            apb_read(a, d);
            vectors++;
            if (d !== model_read(a)) begin
                miscompares++;
                $display("FAIL reserved_wr addr=%0d got=%h exp=%h", a, d, model_read(a));
            end
        end
        apb_read(9, d);
        vectors++;
        if (d !== 8'h00) begin
            miscompares++;
            $display("FAIL reserved_read got=%h exp=00", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d;
        apb_write(0, 8'hFF);
        apb_write(1, 8'hF0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h12;
        @(negedge pclk);
        penable = 1'b1; preset = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; preset = 1'b0;
        model_reset();
        vectors++;
        if (gpio_out !== 8'h00 || gpio_oe !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_pads out=%h oe=%h exp 00/00", gpio_out, gpio_oe);
        end
        for (int a = 0; a < 3; a++) begin
            apb_read(a, d);
            vectors++;
            if (d !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_mid_read addr=%0d got=%h exp=00", a, d);
            end
        end
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_random();
        logic [7:0] d, exp_d, v;
        int a;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = $urandom_range(0, 15);
                    v = 8'($urandom);
                    apb_write(a, v);
                end
                1: begin
                    a = $urandom_range(0, 15);
                    exp_d = model_read(a);
                    apb_read(a, d);
                    vectors++;
                    if (d !== exp_d) begin
                        miscompares++;
                        $display("FAIL rand_read n=%0d addr=%0d got=%h exp=%h", n, a, d, exp_d);
                    end
                end
                default: begin
                    v = 8'($urandom);
                    @(negedge pclk);
                    gpio_in = v;
                    repeat (2) @(negedge pclk);
                    m_in = v;
                end
            endcase
            vectors++;
            if (gpio_out !== model_out() || gpio_oe !== model_oe()) begin
                miscompares++;
                $display("FAIL rand_pads n=%0d out=%h oe=%h exp %h/%h", n, gpio_out, gpio_oe, model_out(), model_oe());
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pull_open_drain();
        test_pin_readback();
        test_access_hold();
        test_reserved();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
